// File: rtl/mem_access_pkg.sv
// Shared op codes, FSM encodings and memory-op decode for the memory-access stage.
// Op codes follow the execute stage's AluOpBus encoding.
package mem_access_pkg;

  localparam int ALUOP_W = 8;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [0:0] MEM_IDLE = 1'b0;
  localparam logic [0:0] MEM_BUS  = 1'b1;

  typedef logic [3:0] mem_sel_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic      is_mem;
    logic      is_store;
    logic      sign;
    mem_size_t size;
  } mem_op_t;

  // Operation captured on entry to BUS; the low address bits steer lane handling.
  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic [1:0]         addr_lo;
    logic [4:0]         wd;
    logic               wreg;
  } mem_lat_t;

  function automatic mem_op_t decode_op(input logic [ALUOP_W-1:0] op);
    mem_op_t d;
    d = '{is_mem: 1'b1, is_store: 1'b0, sign: 1'b0, size: SZ_WORD};
    case (op)
      EXE_LB_OP:  begin d.sign = 1'b1; d.size = SZ_BYTE; end
      EXE_LBU_OP: d.size = SZ_BYTE;
      EXE_LH_OP:  begin d.sign = 1'b1; d.size = SZ_HALF; end
      EXE_LHU_OP: d.size = SZ_HALF;
      EXE_LW_OP:  d.size = SZ_WORD;
      EXE_SB_OP:  begin d.is_store = 1'b1; d.size = SZ_BYTE; end
      EXE_SH_OP:  begin d.is_store = 1'b1; d.size = SZ_HALF; end
      EXE_SW_OP:  d.is_store = 1'b1;
      default:    d.is_mem = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_access_lane_fmt.sv
// Combinational lane formatting: byte-enable and store-data replication for stores,
// lane extraction plus sign/zero extension for loads, and alignment checking.
module mem_lane_fmt
  import mem_access_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [1:0]         addr_lo_i,
  input  logic [31:0]        store_data_i,
  input  logic [31:0]        rdata_i,
  output logic               is_mem_o,
  output logic               is_store_o,
  output logic               misalign_o,
  output mem_sel_t           sel_o,
  output logic [31:0]        wdata_o,
  output logic [31:0]        load_data_o
);

  mem_op_t     w_op;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_op       = decode_op(aluop_i);
  assign is_mem_o   = w_op.is_mem;
  assign is_store_o = w_op.is_store;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    sel_o      = '0;
    wdata_o    = '0;
    misalign_o = 1'b0;
    if (w_op.is_mem) begin
      case (w_op.size)
        SZ_BYTE: begin
          sel_o   = mem_sel_t'(4'b0001 << addr_lo_i);
          wdata_o = {4{store_data_i[7:0]}};
        end
        SZ_HALF: begin
          sel_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o    = {2{store_data_i[15:0]}};
          misalign_o = addr_lo_i[0];
        end
        default: begin
          sel_o      = 4'hF;
          wdata_o    = store_data_i;
          misalign_o = |addr_lo_i;
        end
      endcase
    end
  end

  always_comb begin
    case (addr_lo_i)
      2'd0:    w_byte = rdata_i[7:0];
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      default: w_byte = rdata_i[31:24];
    endcase
    w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (w_op.size)
      SZ_BYTE: load_data_o = {{24{w_op.sign & w_byte[7]}}, w_byte};
      SZ_HALF: load_data_o = {{16{w_op.sign & w_half[15]}}, w_half};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: issues loads/stores on a req/ack data bus with a timeout,
// and registers the write-back result. Non-memory ops pass through in one cycle.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        reg2_i,
  input  logic [4:0]         wd_i,
  input  logic               wreg_i,
  input  logic [31:0]        wdata_i,
  output logic               stallreq_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [31:0]        mem_addr_o,
  output mem_sel_t           mem_sel_o,
  output logic [31:0]        mem_wdata_o,
  input  logic [31:0]        mem_rdata_i,
  input  logic               mem_ack_i,
  output logic               valid_o,
  output logic [4:0]         wd_o,
  output logic               wreg_o,
  output logic [31:0]        wdata_o,
  output logic               misalign_o,
  output logic               bus_err_o
);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  mem_lat_t         r_lat;

  logic             r_req;
  logic             r_we;
  logic [31:0]      r_mem_addr;
  mem_sel_t         r_sel;
  logic [31:0]      r_mem_wdata;

  logic             r_valid;
  logic [4:0]       r_wd;
  logic             r_wreg;
  logic [31:0]      r_wdata;
  logic             r_misalign;
  logic             r_bus_err;

  logic               w_in_bus;
  logic               w_timeout;
  logic [ALUOP_W-1:0] w_fmt_op;
  logic [1:0]         w_fmt_lo;
  logic               w_is_mem;
  logic               w_is_store;
  logic               w_misalign;
  mem_sel_t           w_sel;
  logic [31:0]        w_st_wdata;
  logic [31:0]        w_ld_data;

  assign w_in_bus  = (r_state == MEM_BUS);
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // One formatter serves both phases: live inputs in IDLE, the latched op while in BUS.
  assign w_fmt_op = w_in_bus ? r_lat.aluop   : aluop_i;
  assign w_fmt_lo = w_in_bus ? r_lat.addr_lo : mem_addr_i[1:0];

  mem_lane_fmt u_lane_fmt (
    .aluop_i      (w_fmt_op),
    .addr_lo_i    (w_fmt_lo),
    .store_data_i (reg2_i),
    .rdata_i      (mem_rdata_i),
    .is_mem_o     (w_is_mem),
    .is_store_o   (w_is_store),
    .misalign_o   (w_misalign),
    .sel_o        (w_sel),
    .wdata_o      (w_st_wdata),
    .load_data_o  (w_ld_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= MEM_IDLE;
      r_cnt       <= '0;
      r_lat       <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_sel       <= '0;
      r_mem_wdata <= '0;
      r_valid     <= 1'b0;
      r_wd        <= '0;
      r_wreg      <= 1'b0;
      r_wdata     <= '0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;

      case (r_state)
        MEM_IDLE: begin
          if (valid_i) begin
            if (!w_is_mem) begin
              r_valid <= 1'b1;
              r_wd    <= wd_i;
              r_wreg  <= wreg_i;
              r_wdata <= wdata_i;
            end else if (w_misalign) begin
              r_valid    <= 1'b1;
              r_misalign <= 1'b1;
              r_wd       <= wd_i;
              r_wreg     <= 1'b0;
              r_wdata    <= '0;
            end else begin
              r_state     <= MEM_BUS;
              r_cnt       <= '0;
              r_req       <= 1'b1;
              r_we        <= w_is_store;
              r_mem_addr  <= {mem_addr_i[31:2], 2'b00};
              r_sel       <= w_sel;
              r_mem_wdata <= w_st_wdata;
              r_lat       <= '{aluop: aluop_i, addr_lo: mem_addr_i[1:0],
                               wd: wd_i, wreg: wreg_i};
            end
          end
        end

        default: begin
          // An ack in the final timeout cycle still completes the access normally.
          if (mem_ack_i || w_timeout) begin
            r_state <= MEM_IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_valid <= 1'b1;
            r_wd    <= r_lat.wd;
            if (mem_ack_i) begin
              r_wreg  <= r_we ? 1'b0 : r_lat.wreg;
              r_wdata <= r_we ? 32'h0 : w_ld_data;
            end else begin
              r_bus_err <= 1'b1;
              r_wreg    <= 1'b0;
              r_wdata   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign stallreq_o  = w_in_bus;
  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_sel_o   = r_sel;
  assign mem_wdata_o = r_mem_wdata;

  assign valid_o    = r_valid;
  assign wd_o       = r_wd;
  assign wreg_o     = r_valid & r_wreg;
  assign wdata_o    = r_wdata;
  assign misalign_o = r_misalign;
  assign bus_err_o  = r_bus_err;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected write-back records are queued at issue
// and compared whenever valid_o fires; bus-side behaviour is checked per transaction.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic        stallreq_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        valid_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        misalign_o;
  logic        bus_err_o;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        chk_data;
    logic        misalign;
    logic        bus_err;
  } wb_t;

  wb_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;

  mem_access #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .aluop_i     (aluop_i),
    .mem_addr_i  (mem_addr_i),
    .reg2_i      (reg2_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .stallreq_o  (stallreq_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_sel_o   (mem_sel_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .valid_o     (valid_o),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .misalign_o  (misalign_o),
    .bus_err_o   (bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic wb_t mk_wb(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                                input logic chk, input logic mis, input logic err);
    wb_t e;
    e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.chk_data = chk;
    e.misalign = mis; e.bus_err = err;
    return e;
  endfunction

  // Write-back monitor: every valid_o must match the oldest outstanding expectation.
  wb_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      if (valid_o) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("wb_wreg", 32'(wreg_o), 32'(mon_e.wreg));
          check("wb_misalign", 32'(misalign_o), 32'(mon_e.misalign));
          check("wb_bus_err", 32'(bus_err_o), 32'(mon_e.bus_err));
          if (mon_e.chk_data) begin
            check("wb_wd", 32'(wd_o), 32'(mon_e.wd));
            check("wb_wdata", wdata_o, mon_e.wdata);
          end
        end
      end else begin
        check("idle_flags", 32'({wreg_o, misalign_o, bus_err_o}), 32'd0);
      end
    end
  end

  // Ops that must never touch the bus: ALU pass-through and misaligned accesses.
  task automatic issue_nobus(input string tag, input logic [7:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] wd, input logic wreg,
                             input wb_t exp);
    sb.push_back(exp);
    @(negedge clk);
    aluop_i = op; mem_addr_i = addr; reg2_i = 32'h0BAD_F00D;
    wd_i = wd; wreg_i = wreg; wdata_i = wdata; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    check({tag, "_no_req"}, 32'(mem_req_o), 32'd0);
    check({tag, "_no_stall"}, 32'(stallreq_o), 32'd0);
    @(negedge clk);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  // ack_wait: number of req cycles before the ack cycle; negative means never ack.
  task automatic issue_bus(input string tag, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] reg2, input logic [4:0] wd, input logic wreg,
                           input int ack_wait, input logic [31:0] rdata,
                           input logic exp_we, input logic [3:0] exp_sel,
                           input logic [31:0] exp_mwdata, input wb_t exp);
    int   n_req;
    int   n_stall;
    int   exp_n;
    logic stable;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    sb.push_back(exp);
    @(negedge clk);
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2;
    wd_i = wd; wreg_i = wreg; wdata_i = 32'h5555_AAAA; valid_i = 1'b1;
    @(negedge clk);
    // Upstream keeps presenting a different op while stalled; it must be ignored.
    aluop_i = EXE_ADD_OP; mem_addr_i = ~addr; reg2_i = ~reg2; wreg_i = 1'b1;
    check({tag, "_req"}, 32'(mem_req_o), 32'd1);
    check({tag, "_we"}, 32'(mem_we_o), 32'(exp_we));
    check({tag, "_addr"}, mem_addr_o, exp_addr);
    check({tag, "_sel"}, 32'(mem_sel_o), 32'(exp_sel));
    if (exp_we) check({tag, "_mwdata"}, mem_wdata_o, exp_mwdata);
    n_req = 0; n_stall = 0; stable = 1'b1;
    while (mem_req_o && n_req < 40) begin
      if (stallreq_o) n_stall++;
      if (mem_addr_o !== exp_addr || mem_sel_o !== exp_sel || mem_we_o !== exp_we) stable = 1'b0;
      if (exp_we && mem_wdata_o !== exp_mwdata) stable = 1'b0;
      if (n_req == ack_wait) begin
        mem_ack_i = 1'b1; mem_rdata_i = rdata;
      end
      n_req++;
      @(negedge clk);
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    end
    valid_i = 1'b0;
    exp_n = (ack_wait < 0 || ack_wait >= TIMEOUT) ? TIMEOUT : ack_wait + 1;
    check({tag, "_req_cycles"}, 32'(n_req), 32'(exp_n));
    check({tag, "_stall_cycles"}, 32'(n_stall), 32'(exp_n));
    check({tag, "_bus_stable"}, 32'(stable), 32'd1);
    check({tag, "_stall_done"}, 32'(stallreq_o), 32'd0);
    @(negedge clk);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; valid_i = 1'b0; aluop_i = EXE_NOP_OP; mem_addr_i = '0; reg2_i = '0;
    wd_i = '0; wreg_i = 1'b0; wdata_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          32'({stallreq_o, mem_req_o, mem_we_o, mem_sel_o, valid_o, wreg_o, misalign_o, bus_err_o}),
          32'd0);
    check("reset_addr", mem_addr_o, 32'd0);
    check("reset_wdata", wdata_o, 32'd0);
    rst = 1'b1;

    issue_nobus("add", EXE_ADD_OP, 32'h0, 32'h0000_1234, 5'd5, 1'b1,
                mk_wb(5'd5, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b0));
    issue_nobus("add_nowreg", EXE_ADD_OP, 32'h0, 32'hFEDC_BA98, 5'd9, 1'b0,
                mk_wb(5'd9, 1'b0, 32'hFEDC_BA98, 1'b1, 1'b0, 1'b0));

    issue_bus("lb", EXE_LB_OP, 32'h0000_1003, 32'h0, 5'd7, 1'b1, 3, 32'h80FF_0000,
              1'b0, 4'b1000, 32'h0, mk_wb(5'd7, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0));
    issue_bus("lbu", EXE_LBU_OP, 32'h0000_1003, 32'h0, 5'd8, 1'b1, 3, 32'h80FF_0000,
              1'b0, 4'b1000, 32'h0, mk_wb(5'd8, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 1'b0));
    issue_bus("lb_lane1", EXE_LB_OP, 32'h0000_1001, 32'h0, 5'd3, 1'b1, 0, 32'h1122_7F44,
              1'b0, 4'b0010, 32'h0, mk_wb(5'd3, 1'b1, 32'h0000_007F, 1'b1, 1'b0, 1'b0));
    issue_bus("lh", EXE_LH_OP, 32'h0000_1002, 32'h0, 5'd10, 1'b1, 0, 32'h80FF_0000,
              1'b0, 4'b1100, 32'h0, mk_wb(5'd10, 1'b1, 32'hFFFF_80FF, 1'b1, 1'b0, 1'b0));
    issue_bus("lhu", EXE_LHU_OP, 32'h0000_1000, 32'h0, 5'd11, 1'b1, 1, 32'h1234_8765,
              1'b0, 4'b0011, 32'h0, mk_wb(5'd11, 1'b1, 32'h0000_8765, 1'b1, 1'b0, 1'b0));
    issue_bus("lw", EXE_LW_OP, 32'h0000_1004, 32'h0, 5'd12, 1'b1, 2, 32'hDEAD_BEEF,
              1'b0, 4'hF, 32'h0, mk_wb(5'd12, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0));
    issue_bus("lw_nowreg", EXE_LW_OP, 32'h0000_1008, 32'h0, 5'd13, 1'b0, 0, 32'h0123_4567,
              1'b0, 4'hF, 32'h0, mk_wb(5'd13, 1'b0, 32'h0123_4567, 1'b1, 1'b0, 1'b0));

    issue_bus("sb", EXE_SB_OP, 32'h0000_2001, 32'h1122_33A5, 5'd14, 1'b1, 0, 32'h0,
              1'b1, 4'b0010, 32'hA5A5_A5A5, mk_wb(5'd14, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0));
    issue_bus("sh", EXE_SH_OP, 32'h0000_2002, 32'hABCD_5678, 5'd15, 1'b1, 1, 32'h0,
              1'b1, 4'b1100, 32'h5678_5678, mk_wb(5'd15, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0));
    issue_bus("sw", EXE_SW_OP, 32'h0000_2008, 32'hCAFE_F00D, 5'd16, 1'b1, 0, 32'h0,
              1'b1, 4'hF, 32'hCAFE_F00D, mk_wb(5'd16, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0));

    issue_nobus("lw_mis", EXE_LW_OP, 32'h0000_3001, 32'h0, 5'd17, 1'b1,
                mk_wb(5'd17, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0));
    issue_nobus("lh_mis", EXE_LH_OP, 32'h0000_3003, 32'h0, 5'd18, 1'b1,
                mk_wb(5'd18, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0));
    issue_nobus("sw_mis", EXE_SW_OP, 32'h0000_3002, 32'h0, 5'd19, 1'b1,
                mk_wb(5'd19, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0));

    issue_bus("sw_timeout", EXE_SW_OP, 32'h0000_5000, 32'h1357_9BDF, 5'd20, 1'b1, -1, 32'h0,
              1'b1, 4'hF, 32'h1357_9BDF, mk_wb(5'd20, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
    issue_bus("sw_last_ack", EXE_SW_OP, 32'h0000_5004, 32'h2468_ACE0, 5'd21, 1'b1, TIMEOUT - 1,
              32'h0, 1'b1, 4'hF, 32'h2468_ACE0, mk_wb(5'd21, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0));
    issue_bus("lw_last_ack", EXE_LW_OP, 32'h0000_5008, 32'h0, 5'd22, 1'b1, TIMEOUT - 1,
              32'h7654_3210, 1'b0, 4'hF, 32'h0, mk_wb(5'd22, 1'b1, 32'h7654_3210, 1'b1, 1'b0, 1'b0));

    // Asynchronous reset in the middle of an unacknowledged store.
    @(negedge clk);
    aluop_i = EXE_SW_OP; mem_addr_i = 32'h0000_4000; reg2_i = 32'h1111_2222;
    wd_i = 5'd23; wreg_i = 1'b1; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    check("rst_pre_req", 32'(mem_req_o), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_req_drop", 32'(mem_req_o), 32'd0);
    check("rst_stall_drop", 32'(stallreq_o), 32'd0);
    check("rst_valid_drop", 32'(valid_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    issue_bus("lw_after_rst", EXE_LW_OP, 32'h0000_4004, 32'h0, 5'd24, 1'b1, 1, 32'h0F0F_1234,
              1'b0, 4'hF, 32'h0, mk_wb(5'd24, 1'b1, 32'h0F0F_1234, 1'b1, 1'b0, 1'b0));
    issue_nobus("add_final", EXE_ADD_OP, 32'h0, 32'h0000_00AB, 5'd25, 1'b1,
                mk_wb(5'd25, 1'b1, 32'h0000_00AB, 1'b1, 1'b0, 1'b0));

    repeat (2) @(negedge clk);
    check("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
